// File: rtl/key_debounce_ctrl.sv
// Debounce sequencer for active-low key edge pulses: qualifies press/release with a timed FSM.
// Define KEY_LONGPRESS_EN to build the long-press / auto-repeat pulse generator.
module key_debounce_ctrl #(
  parameter logic [25:0] T_DEBOUNCE = 26'd499_999,
  parameter logic [25:0] T_LONG     = 26'd49_999_999,
  parameter logic [25:0] T_REPEAT   = 26'd4_999_999
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic H2L_Sig,
  input  logic L2H_Sig,
  output logic Press_Sig,
  output logic Release_Sig,
  output logic Key_Level,
  output logic LongPress_Sig
);

  typedef enum logic [1:0] {
    IDLE,
    DB_DOWN,
    PRESSED,
    DB_UP
  } state_t;

  state_t      state, state_next;
  logic [25:0] db_cnt, db_cnt_next;
  logic        press_next, release_next, level_next;
  logic        fall_edge, rise_edge, db_done;

  // Coincident press and release pulses cancel out and count as no edge.
  assign fall_edge = H2L_Sig & ~L2H_Sig;
  assign rise_edge = L2H_Sig & ~H2L_Sig;
  assign db_done   = (db_cnt == T_DEBOUNCE);

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    press_next   = 1'b0;
    release_next = 1'b0;
    level_next   = Key_Level;
    case (state)
      IDLE:    if (fall_edge) state_next = DB_DOWN;
      DB_DOWN: begin
        if (rise_edge) begin
          state_next = IDLE;
        end else if (db_done) begin
          state_next = PRESSED;
          press_next = 1'b1;
          level_next = 1'b1;
        end
      end
      PRESSED: if (rise_edge) state_next = DB_UP;
      DB_UP: begin
        if (fall_edge) begin
          state_next = PRESSED;
        end else if (db_done) begin
          state_next   = IDLE;
          release_next = 1'b1;
          level_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state)
      db_cnt_next = '0;
    else if (state == DB_DOWN || state == DB_UP)
      db_cnt_next = db_cnt + 26'd1;
    else
      db_cnt_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= IDLE;
      db_cnt      <= '0;
      Press_Sig   <= 1'b0;
      Release_Sig <= 1'b0;
      Key_Level   <= 1'b0;
    end else begin
      state       <= state_next;
      db_cnt      <= db_cnt_next;
      Press_Sig   <= press_next;
      Release_Sig <= release_next;
      Key_Level   <= level_next;
    end
  end

`ifdef KEY_LONGPRESS_EN
  logic [25:0] hold_cnt;
  logic        repeat_phase;
  logic        hold_hit;

  // First interval runs to T_LONG, every later one to T_REPEAT; the counter restarts at each tick.
  assign hold_hit = repeat_phase ? (hold_cnt == T_REPEAT) : (hold_cnt == T_LONG);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hold_cnt      <= '0;
      repeat_phase  <= 1'b0;
      LongPress_Sig <= 1'b0;
    end else begin
      LongPress_Sig <= 1'b0;
      if (press_next || !Key_Level) begin
        hold_cnt     <= '0;
        repeat_phase <= 1'b0;
      end else if (hold_hit) begin
        hold_cnt      <= '0;
        repeat_phase  <= 1'b1;
        // A tick landing on the release cycle would be a spurious repeat after the key is up.
        LongPress_Sig <= ~release_next;
      end else begin
        hold_cnt <= hold_cnt + 26'd1;
      end
    end
  end
`else
  assign LongPress_Sig = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Self-checking bench for key_debounce_ctrl: directed scenarios plus randomized edge traffic,
// compared every cycle against a timestamp-based reference model.
module tb_key_debounce_ctrl;

  localparam int DB = 9;
  localparam int LG = 49;
  localparam int RP = 19;

  logic CLK = 1'b0;
  logic RSTn = 1'b1;
  logic H2L_Sig = 1'b0;
  logic L2H_Sig = 1'b0;
  logic Press_Sig, Release_Sig, Key_Level, LongPress_Sig;

  int n_tests = 0;
  int n_fail  = 0;

  key_debounce_ctrl #(
    .T_DEBOUNCE(26'd9),
    .T_LONG    (26'd49),
    .T_REPEAT  (26'd19)
  ) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .H2L_Sig      (H2L_Sig),
    .L2H_Sig      (L2H_Sig),
    .Press_Sig    (Press_Sig),
    .Release_Sig  (Release_Sig),
    .Key_Level    (Key_Level),
    .LongPress_Sig(LongPress_Sig)
  );

  always #5 CLK = ~CLK;

  // Reference model: a debounced level, plus the cycle at which a pending level change was
  // requested. The change is emitted DB+2 cycles after its edge unless an opposite edge cancels it.
  int cyc = 0;
  bit m_level = 1'b0;
  bit m_pend = 1'b0;
  int m_since = 0;
  int m_press_cyc = 0;
  bit e_press, e_rel, e_long, toward_press;

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_long  = 1'b0;
    if (!RSTn) begin
      m_level = 1'b0;
      m_pend  = 1'b0;
    end else if (m_pend && (cyc - m_since == DB + 2)) begin
      m_pend  = 1'b0;
      m_level = ~m_level;
      if (m_level) begin
        e_press     = 1'b1;
        m_press_cyc = cyc;
      end else begin
        e_rel = 1'b1;
      end
    end
`ifdef KEY_LONGPRESS_EN
    if (RSTn && m_level && (cyc > m_press_cyc + LG) &&
        ((cyc - m_press_cyc - LG - 1) % (RP + 1) == 0))
      e_long = 1'b1;
`endif
    check("press",   Press_Sig,     e_press);
    check("release", Release_Sig,   e_rel);
    check("level",   Key_Level,     m_level);
    check("long",    LongPress_Sig, e_long);

    // Apply this cycle's inputs to the model.
    if (RSTn && (H2L_Sig ^ L2H_Sig)) begin
      toward_press = H2L_Sig;
      if (m_pend) begin
        if (toward_press == m_level) m_pend = 1'b0;
      end else if (toward_press != m_level) begin
        m_pend  = 1'b1;
        m_since = cyc;
      end
    end
    cyc++;
  end

  task automatic drive(input logic h, input logic l, input logic rn);
    @(posedge CLK);
    #1;
    H2L_Sig = h;
    L2H_Sig = l;
    RSTn    = rn;
  endtask

  // One stretch of len cycles; pulses at the given cycle offsets (-1 = none), reset low rlo..rhi.
  task automatic run(input int len, input int ha, input int hb, input int la, input int lb,
                     input int rlo, input int rhi);
    for (int c = 0; c < len; c++)
      drive(logic'(c == ha || c == hb), logic'(c == la || c == lb), logic'(!(c >= rlo && c <= rhi)));
  endtask

  initial begin
    int mode;
    int len;
    int r;
    #1 RSTn = 1'b0;

    // Reset held with press pulses present, then idle.
    run(10, 2, 5, -1, -1, 0, 9);
    run(20, -1, -1, -1, -1, -1, -1);
    // Clean press, then clean release.
    run(20, 0, -1, -1, -1, -1, -1);
    run(20, -1, -1, 0, -1, -1, -1);
    // Press bounce: H2L c0, L2H c5, H2L c7.
    run(30, 0, 7, 5, -1, -1, -1);
    // Release bounce: L2H c0, H2L c4, L2H c10.
    run(30, 4, -1, 0, 10, -1, -1);
    // Reset mid-window, then a clean press/release from IDLE.
    run(30, 0, -1, -1, -1, 6, 8);
    run(20, 0, -1, -1, -1, -1, -1);
    run(20, -1, -1, 0, -1, -1, -1);
    // Opposite edge on the timeout cycle wins; simultaneous edges are ignored.
    run(20, 0, -1, 10, -1, -1, -1);
    run(20, 0, -1, 0, -1, -1, -1);
    // Long hold with a release timed onto a repeat tick (press c11, ticks c61, c81, c101).
    run(130, 0, -1, 90, -1, -1, -1);
    // Long hold with a release bounce in the middle, then release.
    run(120, 0, 58, 55, -1, -1, -1);
    run(30, -1, -1, 0, -1, -1, -1);

    // Randomized traffic: bursty bounces, quiet holds and short resets.
    for (int s = 0; s < 80; s++) begin
      mode = $urandom_range(0, 9);
      if (mode < 4) begin
        for (int c = 0; c < 30; c++) begin
          r = $urandom_range(0, 11);
          drive(logic'(r == 0 || r == 2), logic'(r == 1 || r == 2), 1'b1);
        end
      end else if (mode < 9) begin
        len = $urandom_range(5, 120);
        run(len, -1, -1, -1, -1, -1, -1);
      end else begin
        len = $urandom_range(1, 3);
        run(len, 0, -1, -1, -1, 0, len - 1);
      end
    end

    run(5, -1, -1, -1, -1, -1, -1);
    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
